alu_op_sequencer: RTL and testbench

//  Multi-cycle control FSM for the 8-bit CPU datapath: accepts one decoded opcode per handshake.

---
 rtl/alu_ctrl_pkg.sv | 40 ++++
 rtl/alu_op_decoder.sv | 40 ++++
 rtl/alu_op_sequencer.sv | 178 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared opcodes, ALU function codes, FSM states and decoded control bundle
// Imported by alu_op_decoder and alu_op_sequencer. No ports.
package alu_ctrl_pkg;

  localparam int OPW    = 8;
  localparam int ALUOPW = 3;

  localparam logic [OPW-1:0] OP_LOADI = 8'h00;
  localparam logic [OPW-1:0] OP_MOV   = 8'h01;
  localparam logic [OPW-1:0] OP_ADD   = 8'h02;
  localparam logic [OPW-1:0] OP_SUB   = 8'h03;
  localparam logic [OPW-1:0] OP_AND   = 8'h04;
  localparam logic [OPW-1:0] OP_OR    = 8'h05;
  localparam logic [OPW-1:0] OP_J     = 8'h06;
  localparam logic [OPW-1:0] OP_BEQ   = 8'h07;
  localparam logic [OPW-1:0] OP_LWD   = 8'h08;
  localparam logic [OPW-1:0] OP_LWI   = 8'h09;
  localparam logic [OPW-1:0] OP_SWD   = 8'h0A;
  localparam logic [OPW-1:0] OP_SWI   = 8'h0B;
  localparam logic [OPW-1:0] OP_MUL   = 8'h0C;

  localparam logic [ALUOPW-1:0] ALUOP_FWD = 3'b000;
  localparam logic [ALUOPW-1:0] ALUOP_ADD = 3'b001;
  localparam logic [ALUOPW-1:0] ALUOP_AND = 3'b010;
  localparam logic [ALUOPW-1:0] ALUOP_OR  = 3'b011;

  typedef enum logic [2:0] {ST_IDLE, ST_EXEC, ST_MEM, ST_WB, ST_MUL} state_t;

  // Instruction class chosen at decode; steers the EXEC-state branch.
  typedef enum logic [2:0] {K_NONE, K_ALU, K_JUMP, K_BRANCH, K_LOAD, K_STORE, K_MUL} kind_t;

  typedef struct packed {
    logic              legal;
    kind_t             kind;
    logic              twos;
    logic              imm;
    logic [ALUOPW-1:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/alu_op_decoder.sv
// rtl/alu_op_decoder.sv - combinational opcode to control-bundle decoder
// Ports: i_opcode (OPW) opcode to decode; o_ctrl (ctrl_t) legal flag, class, operand mux selects, ALUOP.
// Macro ALU_MUL_SEQ_EN: when defined opcode 0C decodes as a sequenced multiply, otherwise it is illegal.
module alu_op_decoder
  import alu_ctrl_pkg::*;
(
  input  logic [OPW-1:0] i_opcode,
  output ctrl_t          o_ctrl
);

  always_comb begin
    o_ctrl       = '0;
    o_ctrl.legal = 1'b1;
    o_ctrl.aluop = ALUOP_FWD;
    case (i_opcode)
      OP_LOADI: begin o_ctrl.kind = K_ALU; o_ctrl.imm = 1'b1; end
      OP_MOV:   o_ctrl.kind = K_ALU;
      OP_ADD:   begin o_ctrl.kind = K_ALU; o_ctrl.aluop = ALUOP_ADD; end
      OP_SUB:   begin o_ctrl.kind = K_ALU; o_ctrl.aluop = ALUOP_ADD; o_ctrl.twos = 1'b1; end
      OP_AND:   begin o_ctrl.kind = K_ALU; o_ctrl.aluop = ALUOP_AND; end
      OP_OR:    begin o_ctrl.kind = K_ALU; o_ctrl.aluop = ALUOP_OR; end
      OP_J:     o_ctrl.kind = K_JUMP;
      OP_BEQ:   begin o_ctrl.kind = K_BRANCH; o_ctrl.aluop = ALUOP_ADD; o_ctrl.twos = 1'b1; end
      OP_LWD:   o_ctrl.kind = K_LOAD;
      OP_LWI:   begin o_ctrl.kind = K_LOAD; o_ctrl.imm = 1'b1; end
      OP_SWD:   o_ctrl.kind = K_STORE;
      OP_SWI:   begin o_ctrl.kind = K_STORE; o_ctrl.imm = 1'b1; end
      OP_MUL: begin
`ifdef ALU_MUL_SEQ_EN
        o_ctrl.kind  = K_MUL;
        o_ctrl.aluop = ALUOP_ADD;
`else
        o_ctrl.legal = 1'b0;
`endif
      end
      default:  o_ctrl.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - multi-cycle control FSM sequencing ALU, register write-back and data memory
// Ports: i_clk, i_reset (sync, active-high); i_opcode/i_instr_valid/o_instr_ready instruction handshake;
//   i_busywait data cache stall; o_twoscompmux_sel, o_immmux_sel, o_aluop operand/ALU control;
//   o_writeenable register write strobe; o_read/o_write memory request; o_jump/o_branch PC strobes;
//   o_illegal unsupported-opcode pulse; o_mul_step multiply iteration flag.
// Macro ALU_MUL_SEQ_EN: enables the MUL state and step counter (MUL_CYCLES steps); otherwise o_mul_step is 0.
module alu_op_sequencer
  import alu_ctrl_pkg::*;
`ifdef ALU_MUL_SEQ_EN
#(
  parameter int MUL_CYCLES = 8
)
`endif
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [OPW-1:0]    i_opcode,
  input  logic              i_instr_valid,
  output logic              o_instr_ready,
  input  logic              i_busywait,
  output logic              o_twoscompmux_sel,
  output logic              o_immmux_sel,
  output logic [ALUOPW-1:0] o_aluop,
  output logic              o_writeenable,
  output logic              o_read,
  output logic              o_write,
  output logic              o_jump,
  output logic              o_branch,
  output logic              o_illegal,
  output logic              o_mul_step
);

  ctrl_t             w_ctrl;
  state_t            r_state;
  kind_t             r_kind;
  logic              r_ready;
  logic              r_twos;
  logic              r_imm;
  logic [ALUOPW-1:0] r_aluop;
  logic              r_we;
  logic              r_read;
  logic              r_write;
  logic              r_jump;
  logic              r_branch;
  logic              r_illegal;

`ifdef ALU_MUL_SEQ_EN
  localparam int CNTW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  logic            r_mul_step;
  logic [CNTW-1:0] r_mul_cnt;
`endif

  alu_op_decoder u_decoder (
    .i_opcode (i_opcode),
    .o_ctrl   (w_ctrl)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_kind    <= K_NONE;
      r_ready   <= 1'b1;
      r_twos    <= 1'b0;
      r_imm     <= 1'b0;
      r_aluop   <= ALUOP_FWD;
      r_we      <= 1'b0;
      r_read    <= 1'b0;
      r_write   <= 1'b0;
      r_jump    <= 1'b0;
      r_branch  <= 1'b0;
      r_illegal <= 1'b0;
`ifdef ALU_MUL_SEQ_EN
      r_mul_step <= 1'b0;
      r_mul_cnt  <= '0;
`endif
    end else begin
      // One-cycle strobes fall back low unless a branch below re-raises them.
      r_we      <= 1'b0;
      r_jump    <= 1'b0;
      r_branch  <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_instr_valid) begin
            // Decode straight from the bus so EXEC-cycle outputs are already registered.
            r_state   <= ST_EXEC;
            r_ready   <= 1'b0;
            r_kind    <= w_ctrl.kind;
            r_twos    <= w_ctrl.twos;
            r_imm     <= w_ctrl.imm;
            r_aluop   <= w_ctrl.aluop;
            r_jump    <= (w_ctrl.kind == K_JUMP);
            r_branch  <= (w_ctrl.kind == K_BRANCH);
            r_illegal <= !w_ctrl.legal;
          end
        end
        ST_EXEC: begin
          case (r_kind)
            K_ALU:   begin r_state <= ST_WB;  r_we    <= 1'b1; end
            K_LOAD:  begin r_state <= ST_MEM; r_read  <= 1'b1; end
            K_STORE: begin r_state <= ST_MEM; r_write <= 1'b1; end
`ifdef ALU_MUL_SEQ_EN
            K_MUL:   begin r_state <= ST_MUL; r_mul_step <= 1'b1; r_mul_cnt <= '0; end
`endif
            // jump, branch and illegal finish in their single EXEC cycle
            default: begin
              r_state <= ST_IDLE;
              r_ready <= 1'b1;
              r_twos  <= 1'b0;
              r_imm   <= 1'b0;
              r_aluop <= ALUOP_FWD;
            end
          endcase
        end
        ST_MEM: begin
          if (!i_busywait) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
            if (r_kind == K_LOAD) begin
              r_state <= ST_WB;
              r_we    <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_ready <= 1'b1;
              r_twos  <= 1'b0;
              r_imm   <= 1'b0;
              r_aluop <= ALUOP_FWD;
            end
          end
        end
        ST_WB: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_twos  <= 1'b0;
          r_imm   <= 1'b0;
          r_aluop <= ALUOP_FWD;
        end
`ifdef ALU_MUL_SEQ_EN
        ST_MUL: begin
          if (r_mul_cnt == CNTW'(MUL_CYCLES - 1)) begin
            r_mul_step <= 1'b0;
            r_state    <= ST_WB;
            r_we       <= 1'b1;
          end else begin
            r_mul_cnt <= r_mul_cnt + CNTW'(1);
          end
        end
`endif
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_twos  <= 1'b0;
          r_imm   <= 1'b0;
          r_aluop <= ALUOP_FWD;
          r_read  <= 1'b0;
          r_write <= 1'b0;
        end
      endcase
    end
  end

  assign o_instr_ready     = r_ready;
  assign o_twoscompmux_sel = r_twos;
  assign o_immmux_sel      = r_imm;
  assign o_aluop           = r_aluop;
  assign o_writeenable     = r_we;
  assign o_read            = r_read;
  assign o_write           = r_write;
  assign o_jump            = r_jump;
  assign o_branch          = r_branch;
  assign o_illegal         = r_illegal;
`ifdef ALU_MUL_SEQ_EN
  assign o_mul_step        = r_mul_step;
`else
  assign o_mul_step        = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard testbench for alu_op_sequencer
module tb_alu_op_sequencer;

  localparam int C_ALU = 0;
  localparam int C_J   = 1;
  localparam int C_BEQ = 2;
  localparam int C_LD  = 3;
  localparam int C_ST  = 4;
  localparam int C_MUL = 5;
  localparam int C_ILL = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] opcode;
  logic       instr_valid;
  logic       instr_ready;
  logic       busywait;
  logic       twos_sel;
  logic       imm_sel;
  logic [2:0] aluop;
  logic       we;
  logic       rd;
  logic       wr;
  logic       jump;
  logic       branch;
  logic       illegal;
  logic       mul_step;

  logic [31:0] exp_q[$];
  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_opcode          (opcode),
    .i_instr_valid     (instr_valid),
    .o_instr_ready     (instr_ready),
    .i_busywait        (busywait),
    .o_twoscompmux_sel (twos_sel),
    .o_immmux_sel      (imm_sel),
    .o_aluop           (aluop),
    .o_writeenable     (we),
    .o_read            (rd),
    .o_write           (wr),
    .o_jump            (jump),
    .o_branch          (branch),
    .o_illegal         (illegal),
    .o_mul_step        (mul_step)
  );

  // Packs {ready, twos, imm, aluop, we, read, write, jump, branch, illegal, mul_step}.
  function automatic logic [31:0] vec(input logic rdy, input logic tw, input logic im, input logic [2:0] op,
                                      input logic w, input logic r, input logic s, input logic j,
                                      input logic b, input logic il, input logic m);
    return {19'b0, rdy, tw, im, op, w, r, s, j, b, il, m};
  endfunction

  function automatic logic [31:0] idle_vec();
    return vec(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, want);
    end
  endtask

  // Drive inputs for the next rising edge, then sample at the falling edge and score against the queue head.
  task automatic step(input logic v, input logic [7:0] op, input logic bw, input logic rst,
                      input string tag, input int k);
    logic [31:0] want;
    instr_valid = v;
    opcode      = op;
    busywait    = bw;
    reset       = rst;
    @(posedge clk);
    @(negedge clk);
    want = exp_q.pop_front();
    check($sformatf("%s[%0d]", tag, k),
          vec(instr_ready, twos_sel, imm_sel, aluop, we, rd, wr, jump, branch, illegal, mul_step), want);
  endtask

  // Push the expected per-cycle outputs of one instruction, then run it. BUSYWAIT is high for the
  // first nbusy MEM cycles (and during EXEC, where it must be ignored).
  task automatic run_instr(input logic [7:0] op, input int nbusy, input string tag);
    logic       tw;
    logic       im;
    logic [2:0] al;
    int         cls;
    int         n;
    tw = 1'b0; im = 1'b0; al = 3'b000; cls = C_ILL;
    case (op)
      8'h00: begin cls = C_ALU; im = 1'b1; end
      8'h01: cls = C_ALU;
      8'h02: begin cls = C_ALU; al = 3'b001; end
      8'h03: begin cls = C_ALU; al = 3'b001; tw = 1'b1; end
      8'h04: begin cls = C_ALU; al = 3'b010; end
      8'h05: begin cls = C_ALU; al = 3'b011; end
      8'h06: cls = C_J;
      8'h07: begin cls = C_BEQ; al = 3'b001; tw = 1'b1; end
      8'h08: cls = C_LD;
      8'h09: begin cls = C_LD; im = 1'b1; end
      8'h0A: cls = C_ST;
      8'h0B: begin cls = C_ST; im = 1'b1; end
`ifdef ALU_MUL_SEQ_EN
      8'h0C: begin cls = C_MUL; al = 3'b001; end
`endif
      default: cls = C_ILL;
    endcase
    exp_q.push_back(vec(1'b0, tw, im, al, 1'b0, 1'b0, 1'b0, cls == C_J, cls == C_BEQ, cls == C_ILL, 1'b0));
    n = 1;
    case (cls)
      C_ALU: begin
        exp_q.push_back(vec(1'b0, tw, im, al, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); n++;
      end
      C_LD: begin
        for (int i = 0; i <= nbusy; i++) begin
          exp_q.push_back(vec(1'b0, tw, im, al, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); n++;
        end
        exp_q.push_back(vec(1'b0, tw, im, al, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); n++;
      end
      C_ST: begin
        for (int i = 0; i <= nbusy; i++) begin
          exp_q.push_back(vec(1'b0, tw, im, al, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)); n++;
        end
      end
      C_MUL: begin
        for (int i = 0; i < 8; i++) begin
          exp_q.push_back(vec(1'b0, tw, im, al, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)); n++;
        end
        exp_q.push_back(vec(1'b0, tw, im, al, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); n++;
      end
      default: ;
    endcase
    exp_q.push_back(idle_vec()); n++;
    for (int k = 0; k < n; k++) begin
      // After acceptance VALID toggles randomly; the sequencer must ignore it outside IDLE.
      step((k == 0) ? 1'b1 : 1'($urandom_range(0, 1)), op, (k < 2 + nbusy), 1'b0, tag, k);
    end
  endtask

  initial begin
    logic [7:0] b2b [6];
    reset       = 1'b1;
    instr_valid = 1'b0;
    opcode      = 8'h00;
    busywait    = 1'b0;
    b2b = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h05, 8'h03};
    @(negedge clk);

    exp_q.push_back(idle_vec());
    step(1'b0, 8'h00, 1'b0, 1'b1, "reset", 0);
    exp_q.push_back(idle_vec());
    step(1'b0, 8'h00, 1'b1, 1'b0, "idle", 0);

    run_instr(8'h03, 3, "sub");
    for (int i = 0; i < 6; i++) run_instr(b2b[i], 0, $sformatf("b2b%0d", i));
    run_instr(8'h06, 0, "j");
    run_instr(8'h07, 0, "beq");
    run_instr(8'h09, 4, "lwi");
    run_instr(8'h08, 0, "lwd");
    run_instr(8'h0A, 0, "swd");
    run_instr(8'h0B, 2, "swi");
    run_instr(8'hFF, 0, "ill_ff");
    run_instr(8'h0D, 0, "ill_0d");
    run_instr(8'h0C, 0, "mul");

    // Reset while a load is stalled in MEM: request drops, no write-back follows.
    exp_q.push_back(vec(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(vec(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(vec(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(idle_vec());
    exp_q.push_back(idle_vec());
    exp_q.push_back(idle_vec());
    step(1'b1, 8'h08, 1'b1, 1'b0, "rst_mem", 0);
    step(1'b0, 8'h08, 1'b1, 1'b0, "rst_mem", 1);
    step(1'b0, 8'h08, 1'b1, 1'b0, "rst_mem", 2);
    step(1'b0, 8'h08, 1'b1, 1'b1, "rst_mem", 3);
    step(1'b0, 8'h08, 1'b0, 1'b0, "rst_mem", 4);
    step(1'b0, 8'h08, 1'b0, 1'b0, "rst_mem", 5);

    run_instr(8'h02, 0, "add_after_rst");

    check("sb_left", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
